debug_clock_gen: RTL

- Parametrised successor of the fixed 1 Hz debug divider in the CPU debug path.
- Generates a slow, 50%-duty debug clock from the board clock. Divisor is runtime-loadable; load is glitch-free and applied only at a phase boundary.
- Has a run/halt/single-step control FSM, so a human can step the CPU one slow clock at a time.
- Emits a one-cycle TICK strobe in the fast domain for logic that must not be clocked by CLK_OUT.

---
 rtl/debug_clock_gen_pkg.sv | 27 ++
 rtl/debug_clock_gen_if.sv | 24 ++
 rtl/debug_clock_gen_step_debouncer.sv | 42 ++++
 rtl/debug_clock_gen.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/debug_clock_gen_pkg.sv
// Shared encodings and defaults for the debug clock generator.
// Optional feature macro: CLKGEN_STEP_SYNC_EN (synchronised, debounced STEP_REQ).
package debug_clk_pkg;

    localparam int unsigned DEF_CNT_W      = 25;
    localparam int unsigned DEF_DIV_VALUE  = 24999999;
    localparam int unsigned DEF_DEB_CYCLES = 16;

    typedef enum logic [2:0] {
        ST_HALT    = 3'd0,
        ST_RUN     = 3'd1,
        ST_DRAIN   = 3'd2,
        ST_STEP_HI = 3'd3,
        ST_STEP_LO = 3'd4
    } clk_state_e;

    // Codes 10 and 11 also mean halt; only RUN is ever compared against.
    typedef enum logic [1:0] {
        MODE_HALT = 2'b00,
        MODE_RUN  = 2'b01
    } clk_mode_e;

    function automatic logic is_counting(input clk_state_e s);
        return (s == ST_RUN) || (s == ST_DRAIN) || (s == ST_STEP_HI) || (s == ST_STEP_LO);
    endfunction

endpackage

// File: rtl/debug_clock_gen_if.sv
// Control/status bundle between the debug controller and debug_clock_gen.
// Optional feature macro: CLKGEN_STEP_SYNC_EN (no effect on this interface).
interface debug_clock_gen_if #(
    parameter int CNT_W = 25
);
    logic [1:0]       MODE;
    logic             STEP_REQ;
    logic [CNT_W-1:0] DIV_VALUE;
    logic             DIV_LOAD;
    logic             CLK_OUT;
    logic             TICK;
    logic             STEP_BUSY;
    logic             DIV_PENDING;

    modport master (
        output MODE, STEP_REQ, DIV_VALUE, DIV_LOAD,
        input  CLK_OUT, TICK, STEP_BUSY, DIV_PENDING
    );

    modport slave (
        input  MODE, STEP_REQ, DIV_VALUE, DIV_LOAD,
        output CLK_OUT, TICK, STEP_BUSY, DIV_PENDING
    );
endinterface

// File: rtl/debug_clock_gen_step_debouncer.sv
// STEP_REQ conditioning: 2-flop synchroniser, debounce, rising-edge detect.
// Only instantiated when CLKGEN_STEP_SYNC_EN is defined.
module step_debouncer #(
    parameter int unsigned DEB_CYCLES = 16
) (
    input  logic CLK,
    input  logic RESETN,
    input  logic STEP_REQ,
    output logic step_rise
);
    localparam int unsigned DW = $clog2(DEB_CYCLES + 1);

    logic          sync1, sync2;
    logic          deb_level, deb_prev;
    logic [DW-1:0] deb_cnt;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            deb_level <= 1'b0;
            deb_prev  <= 1'b0;
            deb_cnt   <= '0;
        end else begin
            sync1    <= STEP_REQ;
            sync2    <= sync1;
            deb_prev <= deb_level;
            // Counts consecutive samples that disagree with the accepted level.
            if (sync2 == deb_level) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DW'(DEB_CYCLES - 1)) begin
                deb_level <= sync2;
                deb_cnt   <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    assign step_rise = deb_level & ~deb_prev;

endmodule

// File: rtl/debug_clock_gen.sv
// Runtime-loadable 50%-duty debug clock divider with run/halt/single-step control.
// Optional feature macro: CLKGEN_STEP_SYNC_EN selects the synchronised STEP_REQ path.
module debug_clock_gen
    import debug_clk_pkg::*;
#(
    parameter int          CNT_W      = DEF_CNT_W,
    parameter int unsigned DEF_DIV    = DEF_DIV_VALUE,
    parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic                CLK,
    input  logic                RESETN,
    debug_clock_gen_if.slave    dbg
);
    clk_state_e       state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [CNT_W-1:0] active_div, active_d;
    logic [CNT_W-1:0] pend_div, pend_d;
    logic             pending, pending_d;
    logic             clk_out, clk_d;
    logic             tick, tick_d;
    logic             step_rise;

`ifdef CLKGEN_STEP_SYNC_EN
    step_debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_step_debouncer (
        .CLK       (CLK),
        .RESETN    (RESETN),
        .STEP_REQ  (dbg.STEP_REQ),
        .step_rise (step_rise)
    );
`else
    logic step_prev;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) step_prev <= 1'b0;
        else         step_prev <= dbg.STEP_REQ;
    end

    assign step_rise = dbg.STEP_REQ & ~step_prev;
`endif

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state      <= ST_HALT;
            cnt        <= CNT_W'(DEF_DIV);
            active_div <= CNT_W'(DEF_DIV);
            pend_div   <= CNT_W'(DEF_DIV);
            pending    <= 1'b0;
            clk_out    <= 1'b0;
            tick       <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            active_div <= active_d;
            pend_div   <= pend_d;
            pending    <= pending_d;
            clk_out    <= clk_d;
            tick       <= tick_d;
        end
    end

    logic             counting, tc, reload_now, run_req;
    logic [CNT_W-1:0] reload_val;

    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        active_d   = active_div;
        pend_d     = pend_div;
        pending_d  = pending;
        clk_d      = clk_out;
        tick_d     = 1'b0;
        reload_now = 1'b0;

        counting   = is_counting(state);
        tc         = counting && (cnt == '0);
        run_req    = (dbg.MODE == MODE_RUN);
        reload_val = pending ? pend_div : active_div;

        if (counting) begin
            if (tc) reload_now = 1'b1;
            else    cnt_d      = cnt - 1'b1;
        end

        case (state)
            ST_HALT: begin
                clk_d = 1'b0;
                if (pending) reload_now = 1'b1;
                if (run_req) begin
                    state_d = ST_RUN;
                end else if (step_rise) begin
                    state_d    = ST_STEP_HI;
                    reload_now = 1'b1;
                    clk_d      = 1'b1;
                    tick_d     = 1'b1;
                end
            end
            ST_RUN: begin
                if (!run_req) begin
                    // A high phase about to end on this TC needs no drain.
                    if (clk_out && !tc) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d    = ST_HALT;
                        clk_d      = 1'b0;
                        reload_now = 1'b1;
                    end
                end else if (tc) begin
                    clk_d  = ~clk_out;
                    tick_d = ~clk_out;
                end
            end
            ST_DRAIN: begin
                if (run_req) begin
                    state_d = ST_RUN;
                    if (tc) begin
                        clk_d  = ~clk_out;
                        tick_d = ~clk_out;
                    end
                end else if (tc) begin
                    state_d = ST_HALT;
                    clk_d   = 1'b0;
                end
            end
            ST_STEP_HI: begin
                if (tc) begin
                    state_d = ST_STEP_LO;
                    clk_d   = 1'b0;
                end
            end
            ST_STEP_LO: begin
                if (tc) state_d = ST_HALT;
            end
            default: begin
                state_d = ST_HALT;
                clk_d   = 1'b0;
            end
        endcase

        if (reload_now) begin
            cnt_d = reload_val;
            if (pending) begin
                active_d  = pend_div;
                pending_d = 1'b0;
            end
        end

        // Loaded after the reload decision, so a load coincident with TC stays pending.
        if (dbg.DIV_LOAD) begin
            pend_d    = dbg.DIV_VALUE;
            pending_d = 1'b1;
        end
    end

    assign dbg.CLK_OUT     = clk_out;
    assign dbg.TICK        = tick;
    assign dbg.DIV_PENDING = pending;
    assign dbg.STEP_BUSY   = (state == ST_STEP_HI) || (state == ST_STEP_LO);

endmodule
